// File: rtl/serial_addsub_pkg.sv
// Shared types and defaults for the bit-serial add/subtract sequencer.
package serial_addsub_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fas.sv
// Single-bit full adder cell; subtraction comes from an inverted B and a carry-in of 1.
module fas (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer with a start/busy/done handshake.
// Processes one bit per clock, LSB first, through a single fas cell.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_c;
  logic             co_c;
  logic             last_c;
  logic             c_msb_c;

  fas u_fas (
    .a   (opa[0]),
    .b   (opb[0]),
    .cin (carry),
    .s   (sum_c),
    .co  (co_c)
  );

  assign last_c  = (cnt == CW'(WIDTH - 1));
  // On the last bit the running carry is the carry into the MSB.
  assign c_msb_c = carry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      opa      <= '0;
      opb      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opa    <= a;
            opb    <= sub ? ~b : b;
            carry  <= sub;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          result <= {sum_c, result[WIDTH-1:1]};
          carry  <= co_c;
          opa    <= {1'b0, opa[WIDTH-1:1]};
          opb    <= {1'b0, opb[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (last_c) begin
            cout     <= co_c;
            overflow <= c_msb_c ^ co_c;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Bit-serial add/subtract sequencer. It reuses a single full-adder/subtractor cell `fas` to compute a WIDTH-bit sum or difference, one bit per clock, LSB first. A start/busy/done handshake fronts it, so it can serve as the arithmetic engine behind the combinational gate, adder and mux blocks when area matters more than latency.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 2 to 32.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous reset, active-low, sampled on the rising edge of `clk`.
- `start`, input, 1: request an operation; sampled only in IDLE.
- `sub`, input, 1: 0 selects a+b, 1 selects a−b; captured with `start`.
- `a`, input, WIDTH: operand A; captured with `start`.
- `b`, input, WIDTH: operand B; captured with `start`.
- `busy`, output, 1: high in RUN and DONE.
- `done`, output, 1: one-cycle pulse when the result is valid.
- `result`, output, WIDTH: sum or difference; holds its value until the next accepted `start`.
- `cout`, output, 1: carry out. For subtract it is the not-borrow flag (1 means a ≥ b unsigned).
- `overflow`, output, 1: two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE →RUN on `start`=1.
  - RUN→DONE after exactly WIDTH bit-cycles.
  - DONE→IDLE unconditionally.
- Accept on a `start`=1 edge in IDLE:
  - opA ← `a`
  - opB ← `sub` ? ~`b` : `b`
  - carry ← `sub`
  - bit counter ← 0
  - `result` ← 0
- Each RUN edge:
  - `fas` inputs: opA[0], opB[0], carry.
  - Shift `result` right one place; sum enters at bit WIDTH-1.
  - carry ← fas carry output.
  - Shift opA and opB right one place.
  - Counter increments.
  - On the last bit (counter = WIDTH-1), also record the carry-in to the MSB (c_msb).
- Entering DONE:
  - `cout` ← final carry.
  - `overflow` ← c_msb XOR final carry.
  - `done` = 1 for the single DONE cycle.
- `start` is ignored in RUN and DONE: no queuing, no restart.
- `a`, `b` and `sub` may change freely after acceptance.
- All arithmetic is modulo 2^WIDTH. Counter width is $clog2(WIDTH+1).

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `cout`=0, `overflow`=0. State is IDLE and all internal registers are 0.
- Latency: `start` is sampled at edge k. RUN occupies edges k+1 through k+WIDTH. `done` is high in the cycle following edge k+WIDTH, i.e. WIDTH cycles after acceptance.
- Throughput: one operation per WIDTH+2 cycles. The next `start` is first accepted at edge k+WIDTH+2.
- `busy` rises in the cycle after edge k and falls with the DONE→IDLE transition.
- `result` holds intermediate shift contents during RUN and is valid only from `done`.
  - `cout` and `overflow` update only on entry to DONE; otherwise they hold their last value.
- Reset mid-operation (any state): on the next edge everything returns to reset values. The aborted operation never produces `done`.
- Reset and `start` in the same cycle: reset wins and `start` is dropped.

## Structure
- Package `serial_addsub_pkg`:
  - state enum {IDLE, RUN, DONE}
  - default WIDTH constant
- Sub-module: one instance of the existing full-adder/subtractor cell `fas` as the bit-slice datapath. No other sub-modules.
- Counter, shift registers and FSM are inline in `serial_addsub_ctrl`.

## Test plan
- Add, WIDTH=8: 0x0F + 0x01 → `result`=0x10, `cout`=0, `overflow`=0, `done` exactly 8 cycles after the accept edge.
- Carry wrap: 0xFF + 0x01 → `result`=0x00, `cout`=1, `overflow`=0. Then 0x7F + 0x01 → 0x80, `cout`=0, `overflow`=1.
- Subtract: 0x05 − 0x07 → `result`=0xFE, `cout`=0 (borrow), `overflow`=0. Then 0x80 − 0x01 → 0x7F, `cout`=1, `overflow`=1.
- Busy-ignore: pulse `start` with 0x11+0x22, then re-pulse `start` with other operands during RUN and DONE → single `done`, `result`=0x33. A new `start` is accepted only once back in IDLE.
- Reset mid-run: deassert `rst_n` for one cycle at bit 4 of 0xAA+0x55 → all outputs 0 next cycle, no `done`. A following 0x01+0x01 gives 0x02 with normal latency.
- Back-to-back: hold `start` high continuously with changing operands → operations accepted every 10 cycles (WIDTH+2), each result correct.
